// File: rtl/inst_fetch_mod.sv
// rtl/inst_fetch_mod.sv - instruction prefetch FIFO with CB-prefix opcode decode
// Keeps one memory read outstanding while the byte FIFO has room.
module inst_fetch_mod #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        op_valid,
  output logic [8:0]  op_index,
  output logic [15:0] op_pc,
  input  logic        op_take,
  output logic        imm_valid,
  output logic [7:0]  imm_data,
  input  logic        imm_take,
  input  logic        redirect,
  input  logic [15:0] redirect_addr
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   fetch_addr_q, fetch_addr_d;
  logic [15:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    fifo_q [DEPTH];

  logic [7:0] head_byte;
  logic [7:0] second_byte;
  logic       is_cb;
  logic       push;
  logic [1:0] pop_n;

  assign head_byte   = fifo_q[rd_ptr_q];
  assign second_byte = fifo_q[rd_ptr_q + AW'(1)];
  assign is_cb       = (head_byte == 8'hCB);
  assign imm_valid   = (count_q != '0);
  assign imm_data    = head_byte;
  assign op_valid    = is_cb ? (count_q >= CW'(2)) : imm_valid;
  assign op_index    = is_cb ? {1'b1, second_byte} : {1'b0, head_byte};
  assign op_pc       = head_pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_comb begin
    pop_n        = 2'd0;
    push         = 1'b0;
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (op_take && op_valid) begin
      pop_n = is_cb ? 2'd2 : 2'd1;
    end else if (imm_take && imm_valid) begin
      pop_n = 2'd1;
    end
    push = (state_q == WAIT) && mem_ack && !redirect;

    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      head_pc_d    = redirect_addr;
      fetch_addr_d = redirect_addr;
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop_n);
      rd_ptr_d  = rd_ptr_q + AW'(pop_n);
      wr_ptr_d  = wr_ptr_q + AW'(push);
      head_pc_d = head_pc_q + 16'(pop_n);
      if (push) fetch_addr_d = fetch_addr_q + 16'd1;
    end

    // Reissue decisions look at the post-edge count so a push never overflows.
    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < FULL)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (!redirect && (count_d < FULL)) begin
            mem_addr_d = fetch_addr_q + 16'd1;
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      head_pc_q    <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      if (push) fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_inst_fetch_mod.sv
// tb/tb_inst_fetch_mod.sv - scoreboard bench for inst_fetch_mod
// Reference is a queue of {pc, byte} fetched in program order.
module tb_inst_fetch_mod;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        op_valid;
  logic [8:0]  op_index;
  logic [15:0] op_pc;
  logic        op_take;
  logic        imm_valid;
  logic [7:0]  imm_data;
  logic        imm_take;
  logic        redirect;
  logic [15:0] redirect_addr;

  inst_fetch_mod #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_index(op_index), .op_pc(op_pc), .op_take(op_take),
    .imm_valid(imm_valid), .imm_data(imm_data), .imm_take(imm_take),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  b;
  } ent_t;

  ent_t        ref_q[$];
  logic [7:0]  mem [0:65535];
  logic [15:0] exp_fetch;
  logic [15:0] exp_head_pc;
  bit          stale;
  bit          mon_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_op_valid();
    if (ref_q.size() == 0) return 1'b0;
    if (ref_q[0].b == 8'hCB) return ref_q.size() >= 2;
    return 1'b1;
  endfunction

  task automatic model_reset();
    ref_q.delete();
    exp_fetch   = RESET_PC;
    exp_head_pc = RESET_PC;
    stale       = 1'b0;
  endtask

  // Drive one cycle at a negedge, advance the model to the post-edge state, wait a cycle.
  task automatic step(input bit opt, input bit immt, input bit rd, input logic [15:0] ra, input bit ack);
    int   n;
    ent_t e;
    op_take       = opt;
    imm_take      = immt;
    redirect      = rd;
    redirect_addr = ra;
    mem_ack       = ack && mem_req;
    mem_rdata     = mem_ack ? mem[mem_addr] : 8'($urandom);
    if (mem_req) check("req_room", 32'(ref_q.size() < DEPTH), 32'd1);
    if (rd) begin
      if (mem_req && !mem_ack) stale = 1'b1;
      else if (mem_ack) stale = 1'b0;
      ref_q.delete();
      exp_fetch   = ra;
      exp_head_pc = ra;
    end else begin
      n = 0;
      if (opt && ref_op_valid()) n = (ref_q[0].b == 8'hCB) ? 2 : 1;
      else if (immt && ref_q.size() > 0) n = 1;
      repeat (n) void'(ref_q.pop_front());
      exp_head_pc = exp_head_pc + 16'(n);
      if (mem_ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
          e.pc = exp_fetch;
          e.b  = mem[exp_fetch];
          ref_q.push_back(e);
          exp_fetch = exp_fetch + 16'd1;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic wait_req(input string name, input logic [15:0] addr);
    int i;
    i = 0;
    while (!mem_req && i < 8) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      i++;
    end
    check({name, "_req"}, 32'(mem_req), 32'd1);
    check({name, "_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic flush_to(input logic [15:0] addr);
    step(1'b0, 1'b0, 1'b1, addr, 1'b1);
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en && !reset) begin
      check("mon_imm_valid", 32'(imm_valid), 32'(ref_q.size() > 0));
      if (ref_q.size() > 0) begin
        check("mon_imm_data", 32'(imm_data), 32'(ref_q[0].b));
        check("mon_op_pc", 32'(op_pc), 32'(ref_q[0].pc));
      end else begin
        check("mon_op_pc_empty", 32'(op_pc), 32'(exp_head_pc));
      end
      check("mon_op_valid", 32'(op_valid), 32'(ref_op_valid()));
      if (ref_op_valid())
        check("mon_op_index", 32'(op_index),
              32'((ref_q[0].b == 8'hCB) ? {1'b1, ref_q[1].b} : {1'b0, ref_q[0].b}));
    end
  end

  initial begin
    int  acks;
    bit  rd;
    logic [15:0] ra;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    op_take = 1'b0; imm_take = 1'b0; redirect = 1'b0; redirect_addr = 16'h0;
    for (int a = 0; a < 65536; a++) mem[a] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h3E; mem[16'h0002] = 8'h05;
    mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h7C;
    mem[16'h0200] = 8'h11; mem[16'h0201] = 8'h22; mem[16'h0202] = 8'h33; mem[16'h0203] = 8'h44;
    mem[16'h0204] = 8'hAA; mem[16'h0038] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h02; mem[16'h0302] = 8'h03;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(RESET_PC));
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_imm_valid", 32'(imm_valid), 32'd0);
    check("rst_op_index", 32'(op_index), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // sequential fetch 00,3E,05
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr0", 32'(mem_addr), 32'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_op_index0", 32'(op_index), 32'h000);
    check("t1_op_pc0", 32'(op_pc), 32'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t1_op_index1", 32'(op_index), 32'h03E);
    check("t1_op_pc1", 32'(op_pc), 32'h0001);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t1_imm_valid", 32'(imm_valid), 32'd1);
    check("t1_imm_data", 32'(imm_data), 32'h05);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("t1_empty", 32'(imm_valid), 32'd0);
    check("t1_op_pc3", 32'(op_pc), 32'h0003);
    check("t1_addr3", 32'(mem_addr), 32'h0003);

    // CB-prefixed opcode
    flush_to(16'h0100);
    wait_req("t2", 16'h0100);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t2_op_valid_half", 32'(op_valid), 32'd0);
    check("t2_imm_data", 32'(imm_data), 32'hCB);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t2_op_valid", 32'(op_valid), 32'd1);
    check("t2_op_index", 32'(op_index), 32'h17C);
    check("t2_op_pc", 32'(op_pc), 32'h0100);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t2_op_pc_after", 32'(op_pc), 32'h0102);
    check("t2_popped2", 32'(imm_valid), 32'd0);

    // fill to DEPTH, then one pop reopens fetch
    flush_to(16'h0200);
    acks = 0;
    repeat (10) begin
      if (mem_req) acks++;
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    end
    check("t3_ack_count", 32'(acks), 32'(DEPTH));
    check("t3_full_req", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("t3_req_after_pop", 32'(mem_req), 32'd0);
    wait_req("t3_refill", 16'h0204);

    // redirect while waiting, late ack drained
    step(1'b0, 1'b0, 1'b1, 16'h0038, 1'b0);
    check("t4_flushed", 32'(imm_valid), 32'd0);
    check("t4_op_pc", 32'(op_pc), 32'h0038);
    check("t4_drain_addr", 32'(mem_addr), 32'h0204);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t4_discard", 32'(imm_valid), 32'd0);
    check("t4_req_drop", 32'(mem_req), 32'd0);
    wait_req("t4", 16'h0038);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t4_imm_data", 32'(imm_data), 32'h12);

    // address wrap
    flush_to(16'hFFFF);
    wait_req("t5", 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t5_wrap_addr", 32'(mem_addr), 32'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t5_op_pc", 32'(op_pc), 32'h0001);

    // asynchronous reset mid-transaction
    flush_to(16'h0300);
    wait_req("t6", 16'h0300);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t6_pre_req", 32'(mem_req), 32'd1);
    check("t6_pre_valid", 32'(imm_valid), 32'd1);
    mem_ack = 1'b0;
    reset   = 1'b1;
    model_reset();
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'(RESET_PC));
    check("t6_rst_imm_valid", 32'(imm_valid), 32'd0);
    check("t6_rst_op_valid", 32'(op_valid), 32'd0);
    check("t6_rst_op_index", 32'(op_index), 32'd0);
    check("t6_rst_op_pc", 32'(op_pc), 32'(RESET_PC));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t6_first_req", 32'(mem_req), 32'd1);
    check("t6_first_addr", 32'(mem_addr), 32'(RESET_PC));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rd = ($urandom_range(0, 99) < 3);
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25, rd, ra,
           $urandom_range(0, 99) < 60);
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
